// File: rtl/keypad_scanner_if.sv
// Press/release event stream between the keypad scanner (master) and its consumer (slave).
interface keypad_scanner_if #(
    parameter int KeyBits = 4
);
    logic               event_valid;
    logic               event_ready;
    logic [KeyBits-1:0] event_key;
    logic               event_press;

    modport master (
        output event_valid,
        output event_key,
        output event_press,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_key,
        input  event_press,
        output event_ready
    );
endinterface

// File: rtl/keypad_scanner.sv
// Column-multiplexed keypad scanner: settles each driven column, samples the rows,
// debounces every key with its own counter and streams press/release events.
module keypad_scanner #(
    parameter int Rows        = 4,
    parameter int Cols        = 4,
    parameter int SettleTime  = 16,
    parameter int StableCount = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [Cols-1:0]      col_out,
    input  logic [Rows-1:0]      row_in,
    output logic [Rows*Cols-1:0] key_state,
    keypad_scanner_if.master     ev
);

    localparam int NumKeys = Rows * Cols;
    localparam int KeyBits = (NumKeys > 1) ? $clog2(NumKeys) : 1;
    localparam int ColW    = (Cols > 1) ? $clog2(Cols) : 1;
    localparam int SetW    = (SettleTime > 1) ? $clog2(SettleTime) : 1;
    localparam int CntW    = (StableCount > 1) ? $clog2(StableCount) : 1;

    localparam logic [SetW-1:0] SettleInit = SetW'(SettleTime - 1);
    localparam logic [CntW-1:0] CntMax     = CntW'(StableCount - 1);
    localparam logic [ColW-1:0] ColLast    = ColW'(Cols - 1);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        SAMPLE = 2'd1,
        EMIT   = 2'd2
    } state_e;

    function automatic logic [Cols-1:0] col_onehot(input logic [ColW-1:0] idx);
        logic [Cols-1:0] oh;
        oh = '0;
        for (int c = 0; c < Cols; c++) begin
            oh[c] = (idx == ColW'(c));
        end
        return oh;
    endfunction

    function automatic logic [Rows-1:0] lowest_bit(input logic [Rows-1:0] v);
        return v & (~v + Rows'(1));
    endfunction

    function automatic int row_of(input logic [Rows-1:0] onehot);
        int idx;
        idx = 0;
        for (int r = 0; r < Rows; r++) begin
            if (onehot[r]) begin
                idx = r;
            end
        end
        return idx;
    endfunction

    function automatic logic [KeyBits-1:0] key_index(input logic [ColW-1:0] col, input int row);
        return KeyBits'(int'(col) * Rows + row);
    endfunction

    state_e              state_q, state_d;
    logic [ColW-1:0]     col_q, col_d;
    logic [Cols-1:0]     col_out_q, col_out_d;
    logic [SetW-1:0]     settle_q, settle_d;
    logic [NumKeys-1:0]  key_state_q, key_state_d;
    logic [CntW-1:0]     cnt_q [NumKeys];
    logic [CntW-1:0]     cnt_d [NumKeys];
    logic [Rows-1:0]     pending_q, pending_d;
    logic                ev_valid_q, ev_valid_d;
    logic [KeyBits-1:0]  ev_key_q, ev_key_d;
    logic                ev_press_q, ev_press_d;
    logic                advance_s;
    logic [Rows-1:0]     first_s;
    logic [ColW-1:0]     col_next_s;

    assign col_next_s = (col_q == ColLast) ? '0 : col_q + ColW'(1);

    // Next-state logic for the scan FSM, debounce counters and event outputs.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        col_out_d   = col_out_q;
        settle_d    = settle_q;
        key_state_d = key_state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        ev_valid_d  = ev_valid_q;
        ev_key_d    = ev_key_q;
        ev_press_d  = ev_press_q;
        advance_s   = 1'b0;
        first_s     = '0;

        case (state_q)
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            SAMPLE: begin
                // A key flips only after StableCount consecutive disagreeing samples.
                for (int r = 0; r < Rows; r++) begin
                    if (row_in[r] == key_state_q[key_index(col_q, r)]) begin
                        cnt_d[key_index(col_q, r)] = '0;
                    end else if (cnt_q[key_index(col_q, r)] == CntMax) begin
                        key_state_d[key_index(col_q, r)] = ~key_state_q[key_index(col_q, r)];
                        cnt_d[key_index(col_q, r)]       = '0;
                        pending_d[r]                     = 1'b1;
                    end else begin
                        cnt_d[key_index(col_q, r)] = cnt_q[key_index(col_q, r)] + CntW'(1);
                    end
                end
                if (pending_d != '0) begin
                    state_d    = EMIT;
                    first_s    = lowest_bit(pending_d);
                    ev_valid_d = 1'b1;
                    ev_key_d   = key_index(col_q, row_of(first_s));
                    ev_press_d = key_state_d[ev_key_d];
                end else begin
                    advance_s = 1'b1;
                end
            end
            EMIT: begin
                if (ev_valid_q && ev.event_ready) begin
                    pending_d = pending_q & ~lowest_bit(pending_q);
                    if (pending_d != '0) begin
                        first_s    = lowest_bit(pending_d);
                        ev_key_d   = key_index(col_q, row_of(first_s));
                        ev_press_d = key_state_q[ev_key_d];
                    end else begin
                        ev_valid_d = 1'b0;
                        advance_s  = 1'b1;
                    end
                end else begin
                    pending_d = pending_q;
                end
            end
            default: begin
                state_d = SETTLE;
            end
        endcase

        // Moving to the next column is folded into the SAMPLE/EMIT exit.
        if (advance_s) begin
            col_d     = col_next_s;
            col_out_d = col_onehot(col_next_s);
            settle_d  = SettleInit;
            state_d   = SETTLE;
        end else begin
            col_d = col_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SETTLE;
            col_q       <= '0;
            col_out_q   <= col_onehot('0);
            settle_q    <= SettleInit;
            key_state_q <= '0;
            cnt_q       <= '{default: '0};
            pending_q   <= '0;
            ev_valid_q  <= 1'b0;
            ev_key_q    <= '0;
            ev_press_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            col_out_q   <= col_out_d;
            settle_q    <= settle_d;
            key_state_q <= key_state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            ev_valid_q  <= ev_valid_d;
            ev_key_q    <= ev_key_d;
            ev_press_q  <= ev_press_d;
        end
    end

    assign col_out        = col_out_q;
    assign key_state      = key_state_q;
    assign ev.event_valid = ev_valid_q;
    assign ev.event_key   = ev_key_q;
    assign ev.event_press = ev_press_q;

endmodule
